base_tracker: RTL and testbench
===============================

BASE_TRACKER -- requirements
Module: base_tracker

Interface
REQ-001 Parameter NUM_BASES, default 3, number of bases excluding home plate; legal range 3..7.
REQ-002 Parameter RUN_W, default 8, width of the cumulative score register.
REQ-003 Parameter OUTS_PER_INNING, default 3, outs that end a half-inning; legal range 1..3.
REQ-004 clk  in  1  clock; all state updates on the rising edge.
REQ-005 reset_n  in  1  reset, asynchronous, active-low.
REQ-006 ev_valid  in  1  event offered this cycle.
REQ-007 ev_code  in  3  event: 1 single, 2 double, 3 triple, 4 home run, 5 walk, 6 out; 0 and 7 are no-ops.
REQ-008 ev_ready  out  1  block can accept an event this cycle.
REQ-009 base  out  NUM_BASES  occupancy; bit0 = first base, bit NUM_BASES-1 = last base before home.
REQ-010 runs  out  3  runs scored by the last accepted event; holds until the next accepted event.
REQ-011 score  out  RUN_W  cumulative runs since reset, saturating.
REQ-012 outs  out  2  outs in the current half-inning.
REQ-013 inning_end  out  1  one-cycle pulse when a half-inning closes.

Function
REQ-014 An event is accepted when ev_valid and ev_ready are both high on a rising edge; no-op codes are accepted with no state change, and runs is cleared to 0.
REQ-015 All outputs are registered; effects of an accepted event are visible the cycle after acceptance (latency 1).
REQ-016 Hit of k bases (k = 1..3): new base = (base << k) | (1 << (k-1)) truncated to NUM_BASES bits; runs = number of occupied bits shifted past bit NUM_BASES-1.
REQ-017 Home run: base cleared to 0; runs = popcount(base) + 1.
REQ-018 Walk (forced advance only): batter to bit0; a runner on bit i moves only if bits 0..i are all occupied; runs = 1 only when all bases were occupied, else 0.
REQ-019 Out: no runner movement; runs = 0; outs increments unless it would reach OUTS_PER_INNING.
REQ-020 Out that reaches OUTS_PER_INNING: outs <= 0, base <= 0, inning_end pulses high for exactly one cycle, FSM enters CLEAR.
REQ-021 score <= min(score + runs, 2^RUN_W - 1); the addition is performed at RUN_W+3 bits before saturation.
REQ-022 FSM states: PLAY (ev_ready = 1) and CLEAR (ev_ready = 0); PLAY -> CLEAR on REQ-020; CLEAR -> PLAY unconditionally after one cycle.
REQ-023 In CLEAR, ev_valid is ignored; the upstream holds the event and it is accepted in the following PLAY cycle.
REQ-024 score is not cleared at inning end; only reset clears it.

Reset
REQ-025 Asserting reset_n low, including mid-event or in CLEAR, immediately forces base = 0, runs = 0, score = 0, outs = 0, inning_end = 0, FSM = PLAY.
REQ-026 ev_ready is 1 on the first rising edge after reset_n deasserts.

Structure
REQ-027 Event-code constants and FSM state encodings reside in the shared package base_pkg.
REQ-028 The advance logic (REQ-016..018: base vector and code in, new vector and runs out) is the purely combinational sub-module base_advance; the FSM, counters and output registers reside in base_tracker.

Verification (NUM_BASES = 3 unless noted)
REQ-029 Reset -> base = 000, score = 0, outs = 0, ev_ready = 1, inning_end = 0.
REQ-030 Single x3 then double -> base = 111, then base = 110, runs = 2, score = 2.
REQ-031 base = 101, walk -> base = 111, runs = 0; walk again -> base = 111, runs = 1.
REQ-032 base = 111, home run -> base = 000, runs = 4, score +4.
REQ-033 base = 011, three outs with ev_valid held high -> inning_end pulses once, base = 000, outs = 0, ev_ready low for one cycle, a held single is accepted only afterward.
REQ-034 RUN_W = 3, score = 6, home run -> score = 7 (saturated); reset asserted in CLEAR -> all outputs 0, ev_ready = 1.

Source files
------------

// File: rtl/base_pkg.sv
// rtl/base_pkg.sv - event codes and FSM state encodings shared by the base tracker
package base_pkg;

   typedef enum logic [2:0] {
      EV_NOP0   = 3'd0,
      EV_SINGLE = 3'd1,
      EV_DOUBLE = 3'd2,
      EV_TRIPLE = 3'd3,
      EV_HOMER  = 3'd4,
      EV_WALK   = 3'd5,
      EV_OUT    = 3'd6,
      EV_NOP7   = 3'd7
   } ev_code_e;

   typedef enum logic {
      ST_PLAY  = 1'b0,
      ST_CLEAR = 1'b1
   } state_e;

endpackage

// File: rtl/base_tracker_if.sv
// rtl/base_tracker_if.sv - event handshake between the play feed and the base tracker
interface base_tracker_if;

   logic       ev_valid;
   logic [2:0] ev_code;
   logic       ev_ready;

   modport master (output ev_valid, output ev_code, input ev_ready);
   modport slave  (input ev_valid, input ev_code, output ev_ready);

endinterface

// File: rtl/base_advance.sv
// rtl/base_advance.sv - combinational runner advance for hits, home runs and walks
module base_advance
   import base_pkg::*;
#(
   parameter int NUM_BASES = 3
) (
   input  logic [NUM_BASES-1:0] base_in,
   input  logic [2:0]           code,
   output logic [NUM_BASES-1:0] base_out,
   output logic [2:0]           runs
);

   localparam int EW = NUM_BASES + 3;

   logic [EW-1:0] ext;
   logic [3:0]    cnt;
   logic          carry;

   always_comb begin
      ext      = '0;
      cnt      = '0;
      carry    = 1'b1;
      base_out = base_in;
      case (ev_code_e'(code))
         EV_SINGLE, EV_DOUBLE, EV_TRIPLE: begin
            // bits pushed past the last base are the runners who scored
            ext      = ({3'b000, base_in} << code) | (EW'(1) << (code - 3'd1));
            base_out = ext[NUM_BASES-1:0];
            for (int i = 0; i < 3; i++)
               cnt = cnt + {3'b000, ext[NUM_BASES+i]};
         end
         EV_HOMER: begin
            base_out = '0;
            cnt      = 4'd1;
            for (int i = 0; i < NUM_BASES; i++)
               cnt = cnt + {3'b000, base_in[i]};
         end
         EV_WALK: begin
            for (int i = 0; i < NUM_BASES; i++) begin
               base_out[i] = base_in[i] | carry;
               carry       = carry & base_in[i];
            end
            cnt = {3'b000, carry};
         end
         default: ;
      endcase
      // only a home run with seven full bases exceeds the 3-bit runs field
      runs = (cnt > 4'd7) ? 3'd7 : cnt[2:0];
   end

endmodule

// File: rtl/base_tracker.sv
// rtl/base_tracker.sv - base occupancy, score and out tracking with half-inning clear
module base_tracker
   import base_pkg::*;
#(
   parameter int NUM_BASES       = 3,
   parameter int RUN_W           = 8,
   parameter int OUTS_PER_INNING = 3
) (
   input  logic                 clk,
   input  logic                 reset_n,
   base_tracker_if.slave        ev,
   output logic [NUM_BASES-1:0] base,
   output logic [2:0]           runs,
   output logic [RUN_W-1:0]     score,
   output logic [1:0]           outs,
   output logic                 inning_end
);

   localparam logic [1:0] LAST_OUT = 2'(OUTS_PER_INNING - 1);

   state_e               state, state_nxt;
   logic                 accept, is_out, final_out;
   logic [NUM_BASES-1:0] adv_base;
   logic [2:0]           adv_runs;
   logic [RUN_W+2:0]     sum;

   base_advance #(.NUM_BASES(NUM_BASES)) u_advance (
      .base_in  (base),
      .code     (ev.ev_code),
      .base_out (adv_base),
      .runs     (adv_runs)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= ST_PLAY;
      else          state <= state_nxt;
   end

   always_comb begin
      state_nxt   = state;
      ev.ev_ready = (state == ST_PLAY);
      accept      = ev.ev_valid && (state == ST_PLAY);
      is_out      = (ev_code_e'(ev.ev_code) == EV_OUT);
      final_out   = accept && is_out && (outs == LAST_OUT);
      case (state)
         ST_PLAY:  if (final_out) state_nxt = ST_CLEAR;
         ST_CLEAR: state_nxt = ST_PLAY;
         default:  state_nxt = ST_PLAY;
      endcase
   end

   assign sum = {3'b000, score} + {{RUN_W{1'b0}}, adv_runs};

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         base       <= '0;
         runs       <= '0;
         score      <= '0;
         outs       <= '0;
         inning_end <= 1'b0;
      end else begin
         inning_end <= final_out;
         if (accept) begin
            runs  <= adv_runs;
            score <= (sum[RUN_W+2:RUN_W] != 3'b000) ? {RUN_W{1'b1}} : sum[RUN_W-1:0];
            if (final_out) begin
               outs <= '0;
               base <= '0;
            end else begin
               base <= adv_base;
               if (is_out) outs <= outs + 2'd1;
            end
         end
      end
   end

endmodule

// File: tb/tb_base_tracker.sv
// tb/tb_base_tracker.sv - directed self-checking bench for base_tracker
module tb_base_tracker;

   logic       clk = 1'b0;
   logic       reset_n;
   logic [2:0] base_a, runs_a, base_b, runs_b, score_b;
   logic [7:0] score_a;
   logic [1:0] outs_a, outs_b;
   logic       ie_a, ie_b;
   int         passed = 0;
   int         total = 0;

   always #5 clk = ~clk;

   base_tracker_if ifa ();
   base_tracker_if ifb ();

   base_tracker #(.NUM_BASES(3), .RUN_W(8), .OUTS_PER_INNING(3)) dut_a (
      .clk(clk), .reset_n(reset_n), .ev(ifa), .base(base_a), .runs(runs_a),
      .score(score_a), .outs(outs_a), .inning_end(ie_a)
   );

   base_tracker #(.NUM_BASES(3), .RUN_W(3), .OUTS_PER_INNING(3)) dut_b (
      .clk(clk), .reset_n(reset_n), .ev(ifb), .base(base_b), .runs(runs_b),
      .score(score_b), .outs(outs_b), .inning_end(ie_b)
   );

   task automatic send_a(input logic [2:0] code);
      @(negedge clk);
      ifa.ev_valid = 1'b1;
      ifa.ev_code  = code;
      @(posedge clk);
      #1;
      ifa.ev_valid = 1'b0;
      ifa.ev_code  = 3'd0;
   endtask

   task automatic send_b(input logic [2:0] code);
      @(negedge clk);
      ifb.ev_valid = 1'b1;
      ifb.ev_code  = code;
      @(posedge clk);
      #1;
      ifb.ev_valid = 1'b0;
      ifb.ev_code  = 3'd0;
   endtask

   task automatic test_reset;
      reset_n = 1'b0;
      ifa.ev_valid = 1'b0; ifa.ev_code = 3'd0;
      ifb.ev_valid = 1'b0; ifb.ev_code = 3'd0;
      repeat (2) @(posedge clk);
      #1;
      total++; if (base_a !== 3'b000) $display("FAIL reset_base got %b want 000", base_a); else passed++;
      total++; if (score_a !== 8'd0) $display("FAIL reset_score got %0d want 0", score_a); else passed++;
      total++; if (outs_a !== 2'd0) $display("FAIL reset_outs got %0d want 0", outs_a); else passed++;
      total++; if (ie_a !== 1'b0) $display("FAIL reset_inning_end got %b want 0", ie_a); else passed++;
      total++; if (runs_a !== 3'd0) $display("FAIL reset_runs got %0d want 0", runs_a); else passed++;
      @(negedge clk);
      reset_n = 1'b1;
      @(posedge clk);
      #1;
      total++; if (ifa.ev_ready !== 1'b1) $display("FAIL reset_ready got %b want 1", ifa.ev_ready); else passed++;
   endtask

   task automatic test_hits;
      send_a(3'd1);
      total++; if (base_a !== 3'b001) $display("FAIL single1_base got %b want 001", base_a); else passed++;
      send_a(3'd1);
      send_a(3'd1);
      total++; if (base_a !== 3'b111) $display("FAIL single3_base got %b want 111", base_a); else passed++;
      total++; if (runs_a !== 3'd0) $display("FAIL single3_runs got %0d want 0", runs_a); else passed++;
      send_a(3'd2);
      total++; if (base_a !== 3'b110) $display("FAIL double_base got %b want 110", base_a); else passed++;
      total++; if (runs_a !== 3'd2) $display("FAIL double_runs got %0d want 2", runs_a); else passed++;
      total++; if (score_a !== 8'd2) $display("FAIL double_score got %0d want 2", score_a); else passed++;
      send_a(3'd4);
      total++; if (runs_a !== 3'd3) $display("FAIL hr2_runs got %0d want 3", runs_a); else passed++;
      total++; if (score_a !== 8'd5) $display("FAIL hr2_score got %0d want 5", score_a); else passed++;
      send_a(3'd3);
      total++; if (base_a !== 3'b100) $display("FAIL triple_base got %b want 100", base_a); else passed++;
   endtask

   task automatic test_walk;
      send_a(3'd5);
      total++; if (base_a !== 3'b101) $display("FAIL walk1_base got %b want 101", base_a); else passed++;
      send_a(3'd5);
      total++; if (base_a !== 3'b111) $display("FAIL walk2_base got %b want 111", base_a); else passed++;
      total++; if (runs_a !== 3'd0) $display("FAIL walk2_runs got %0d want 0", runs_a); else passed++;
      send_a(3'd5);
      total++; if (base_a !== 3'b111) $display("FAIL walk3_base got %b want 111", base_a); else passed++;
      total++; if (runs_a !== 3'd1) $display("FAIL walk3_runs got %0d want 1", runs_a); else passed++;
      total++; if (score_a !== 8'd6) $display("FAIL walk3_score got %0d want 6", score_a); else passed++;
   endtask

   task automatic test_home_run;
      send_a(3'd4);
      total++; if (base_a !== 3'b000) $display("FAIL grand_slam_base got %b want 000", base_a); else passed++;
      total++; if (runs_a !== 3'd4) $display("FAIL grand_slam_runs got %0d want 4", runs_a); else passed++;
      total++; if (score_a !== 8'd10) $display("FAIL grand_slam_score got %0d want 10", score_a); else passed++;
   endtask

   task automatic test_noop;
      send_a(3'd0);
      total++; if (runs_a !== 3'd0) $display("FAIL noop0_runs got %0d want 0", runs_a); else passed++;
      send_a(3'd1);
      send_a(3'd7);
      total++; if (base_a !== 3'b001) $display("FAIL noop7_base got %b want 001", base_a); else passed++;
      total++; if (score_a !== 8'd10) $display("FAIL noop7_score got %0d want 10", score_a); else passed++;
   endtask

   task automatic test_inning_end;
      send_a(3'd1);
      total++; if (base_a !== 3'b011) $display("FAIL pre_out_base got %b want 011", base_a); else passed++;
      @(negedge clk);
      ifa.ev_valid = 1'b1;
      ifa.ev_code  = 3'd6;
      @(posedge clk); #1;
      total++; if (outs_a !== 2'd1) $display("FAIL out1_outs got %0d want 1", outs_a); else passed++;
      total++; if (base_a !== 3'b011) $display("FAIL out1_base got %b want 011", base_a); else passed++;
      @(posedge clk); #1;
      total++; if (outs_a !== 2'd2) $display("FAIL out2_outs got %0d want 2", outs_a); else passed++;
      total++; if (ie_a !== 1'b0) $display("FAIL out2_inning_end got %b want 0", ie_a); else passed++;
      @(posedge clk); #1;
      total++; if (ie_a !== 1'b1) $display("FAIL out3_inning_end got %b want 1", ie_a); else passed++;
      total++; if (outs_a !== 2'd0) $display("FAIL out3_outs got %0d want 0", outs_a); else passed++;
      total++; if (base_a !== 3'b000) $display("FAIL out3_base got %b want 000", base_a); else passed++;
      total++; if (ifa.ev_ready !== 1'b0) $display("FAIL clear_ready got %b want 0", ifa.ev_ready); else passed++;
      total++; if (score_a !== 8'd10) $display("FAIL out3_score got %0d want 10", score_a); else passed++;
      ifa.ev_code = 3'd1;
      @(posedge clk); #1;
      total++; if (ie_a !== 1'b0) $display("FAIL pulse_width got %b want 0", ie_a); else passed++;
      total++; if (base_a !== 3'b000) $display("FAIL held_single_early got %b want 000", base_a); else passed++;
      total++; if (ifa.ev_ready !== 1'b1) $display("FAIL play_ready got %b want 1", ifa.ev_ready); else passed++;
      @(posedge clk); #1;
      ifa.ev_valid = 1'b0;
      ifa.ev_code  = 3'd0;
      total++; if (base_a !== 3'b001) $display("FAIL held_single_base got %b want 001", base_a); else passed++;
   endtask

   task automatic test_saturate;
      send_b(3'd4);
      send_b(3'd4);
      total++; if (score_b !== 3'd2) $display("FAIL sat_pre_score got %0d want 2", score_b); else passed++;
      send_b(3'd3); send_b(3'd4);
      send_b(3'd3); send_b(3'd4);
      total++; if (score_b !== 3'd6) $display("FAIL sat_six_score got %0d want 6", score_b); else passed++;
      send_b(3'd3); send_b(3'd4);
      total++; if (runs_b !== 3'd2) $display("FAIL sat_runs got %0d want 2", runs_b); else passed++;
      total++; if (score_b !== 3'd7) $display("FAIL sat_score got %0d want 7", score_b); else passed++;
      send_b(3'd4);
      total++; if (score_b !== 3'd7) $display("FAIL sat_hold_score got %0d want 7", score_b); else passed++;
   endtask

   task automatic test_reset_in_clear;
      send_b(3'd1);
      send_b(3'd6); send_b(3'd6); send_b(3'd6);
      total++; if (ifb.ev_ready !== 1'b0) $display("FAIL b_clear_ready got %b want 0", ifb.ev_ready); else passed++;
      total++; if (ie_b !== 1'b1) $display("FAIL b_inning_end got %b want 1", ie_b); else passed++;
      reset_n = 1'b0;
      #1;
      total++; if (score_b !== 3'd0) $display("FAIL rst_clear_score got %0d want 0", score_b); else passed++;
      total++; if (ie_b !== 1'b0) $display("FAIL rst_clear_inning_end got %b want 0", ie_b); else passed++;
      total++; if (runs_b !== 3'd0) $display("FAIL rst_clear_runs got %0d want 0", runs_b); else passed++;
      total++; if (base_b !== 3'b000) $display("FAIL rst_clear_base got %b want 000", base_b); else passed++;
      total++; if (outs_b !== 2'd0) $display("FAIL rst_clear_outs got %0d want 0", outs_b); else passed++;
      total++; if (ifb.ev_ready !== 1'b1) $display("FAIL rst_clear_ready got %b want 1", ifb.ev_ready); else passed++;
      @(negedge clk);
      reset_n = 1'b1;
   endtask

   initial begin
      test_reset;
      test_hits;
      test_walk;
      test_home_run;
      test_noop;
      test_inning_end;
      test_saturate;
      test_reset_in_clear;
      repeat (2) @(posedge clk);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
